cluster_accumulator: RTL and testbench
======================================

Name: cluster_accumulator

Overview:
Per-cluster accumulation and centroid-update stage for the k-means datapath. One instance sits on each of the eight outputs of the point-routing demux, which steers each classified point to the cluster of its nearest centroid. Each instance sums the coordinates of every point routed to it and counts those points. On command it computes the new centroid as the floor mean per coordinate, using a sequential restoring divider. The result is presented to the centroid register bank.

Parameters:
COORD_NUM, 7, number of coordinates per point; the point bus width is COORD_NUM*COORD_WIDTH = 91.
COORD_WIDTH, 13, width of one unsigned coordinate; coordinate i occupies bits [i*COORD_WIDTH +: COORD_WIDTH], with coordinate 0 in the LSBs.
CNT_WIDTH, 16, width of the point counter. Each per-coordinate sum is COORD_WIDTH+CNT_WIDTH bits wide and therefore cannot overflow.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
clear  input  1  synchronous clear of accumulators and flags; starts a new iteration.
point_valid  input  1  point_in is a real point for this cluster this cycle. Required because an all-zero point is legal data.
point_in  input  COORD_NUM*COORD_WIDTH  packed point from the demux output.
old_centroid_in  input  COORD_NUM*COORD_WIDTH  current centroid; reused if the cluster is empty.
compute_start  input  1  begin the mean computation.
busy  output  1  high while in DIVIDE.
centroid_valid  output  1  high (level) while in DONE.
centroid_out  output  COORD_NUM*COORD_WIDTH  computed centroid.
count_out  output  CNT_WIDTH  current point count.
empty_cluster  output  1  the last computation found count = 0.
overflow  output  1  sticky; a point was dropped because the count was saturated.

Behaviour:
- States: ACCUM, DIVIDE, DONE.
- Reset (rst_n low, asynchronous) sets:
  - state ACCUM;
  - all sums, count, divider registers, centroid_out, count_out, busy, centroid_valid, empty_cluster and overflow to 0.
- Reset mid-DIVIDE aborts the division immediately; there is no partial result.
- clear (any state) takes effect at the next edge:
  - state goes to ACCUM;
  - sums, count, overflow, empty_cluster and centroid_valid go to 0;
  - centroid_out retains its value.
  - clear has priority over point_valid and compute_start in the same cycle.
- ACCUM:
  - When point_valid=1, each sum[i] += coord i (zero-extended) and count += 1 at the edge.
  - If count = 2^CNT_WIDTH-1, the point is dropped, sums and count are unchanged, and overflow is set.
- compute_start in ACCUM:
  - If point_valid is also high, that point is accumulated first and is included in the mean.
  - If the resulting count = 0: centroid_out <= old_centroid_in, empty_cluster <= 1, state goes to DONE. centroid_valid is high 1 cycle after the compute_start edge.
  - Otherwise: state goes to DIVIDE, the coordinate index goes to 0, and busy = 1.
- DIVIDE:
  - Restoring division of sum[i] by count, one quotient bit per cycle, MSB first.
  - Only COORD_WIDTH quotient bits are produced, since the mean is never larger than the maximum coordinate.
  - The result is the floor (truncated) mean and is written to centroid_out coordinate i. Coordinates are processed 0 to COORD_NUM-1.
  - Total time is COORD_NUM*COORD_WIDTH cycles (91 at defaults). centroid_valid goes high exactly 92 cycles after the compute_start sampling edge, and busy drops in the same cycle.
  - centroid_out coordinates not yet computed may hold intermediate values; they are only defined when centroid_valid = 1.
- Outside ACCUM:
  - point_valid is ignored in DIVIDE and DONE; sums are frozen.
  - compute_start is ignored in DIVIDE and DONE.
- DONE:
  - centroid_valid = 1 and centroid_out is stable; count_out keeps the final count.
  - The block remains in DONE until clear.
- count_out always reflects the registered count.

Test Plan:
1. Reset, then 4 points with every coordinate equal to 10, 20, 30 and 40 in turn, then compute_start -> busy for 91 cycles; centroid_valid rises 92 cycles after the start edge; every coordinate = 25; count_out = 4.
2. Two points with coord0 = 1 then 2 (other coordinates 0) -> coord0 = 1 (floor), others 0. Separately, 3 points with all coordinates 8191 -> all coordinates 8191.
3. compute_start with no points -> 1 cycle later centroid_valid = 1, empty_cluster = 1, centroid_out = old_centroid_in (e.g. all coordinates 0x155); busy never rises.
4. Simultaneous events:
   - point_valid (coords 6) together with compute_start after one earlier point (coords 2) -> count_out = 2, mean = 4.
   - clear together with point_valid -> count_out = 0, sums 0.
   - point_valid during DIVIDE -> ignored; result unchanged.
5. rst_n low at cycle 40 of DIVIDE -> all outputs 0 asynchronously. After release, 1 point (coords 7) and compute_start -> centroid 7.
6. CNT_WIDTH = 4: 17 valid points of coords 1 -> count_out = 15, overflow = 1, mean = 1. clear -> overflow = 0, count_out = 0.

Source files
------------

// File: rtl/cluster_accumulator.sv
// Per-cluster point accumulator for the k-means datapath: sums coordinates and counts
// routed points, then produces the floor-mean centroid with a bit-serial restoring divider.
module cluster_accumulator #(
   parameter int COORD_NUM   = 7,
   parameter int COORD_WIDTH = 13,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             clear,
   input  logic                             point_valid,
   input  logic [COORD_NUM*COORD_WIDTH-1:0] point_in,
   input  logic [COORD_NUM*COORD_WIDTH-1:0] old_centroid_in,
   input  logic                             compute_start,
   output logic                             busy,
   output logic                             centroid_valid,
   output logic [COORD_NUM*COORD_WIDTH-1:0] centroid_out,
   output logic [CNT_WIDTH-1:0]             count_out,
   output logic                             empty_cluster,
   output logic                             overflow
);
   localparam int SUM_W = COORD_WIDTH + CNT_WIDTH;
   localparam int IDX_W = (COORD_NUM > 1) ? $clog2(COORD_NUM) : 1;
   localparam int BIT_W = (COORD_WIDTH > 1) ? $clog2(COORD_WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COORD_NUM - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(COORD_WIDTH - 1);

   typedef enum logic [1:0] {ACCUM, DIVIDE, DONE} state_t;
   state_t state_q, state_d;

   logic [SUM_W-1:0]       sum_q  [COORD_NUM];
   logic [COORD_WIDTH-1:0] cent_q [COORD_NUM];
   logic [CNT_WIDTH-1:0]   count_q;
   logic [CNT_WIDTH-1:0]   rem_q;
   logic [IDX_W-1:0]       idx_q;
   logic [BIT_W-1:0]       bit_q;
   logic busy_q, valid_q, empty_q, ovf_q;
   logic busy_d, valid_d;

   logic                   take_pt, add_pt, start, now_empty, last_step;
   logic [SUM_W-1:0]       sum_cur;
   logic [COORD_WIDTH-1:0] sum_lo;
   logic [BIT_W-1:0]       bsel;
   logic [CNT_WIDTH-1:0]   rem_in, rem_nx;
   logic [CNT_WIDTH:0]     trial;
   logic                   q_bit;

   assign take_pt   = (state_q == ACCUM) && point_valid && !clear;
   assign add_pt    = take_pt && !(&count_q);
   assign start     = (state_q == ACCUM) && compute_start && !clear;
   assign now_empty = (count_q == '0) && !add_pt;
   assign last_step = (bit_q == LAST_BIT);

   // Quotient fits in COORD_WIDTH bits, so the sum's upper CNT_WIDTH bits seed the remainder.
   always_comb begin
      sum_cur = sum_q[idx_q];
      sum_lo  = sum_cur[COORD_WIDTH-1:0];
      bsel    = LAST_BIT - bit_q;
      rem_in  = (bit_q == '0) ? sum_cur[SUM_W-1:COORD_WIDTH] : rem_q;
      trial   = {rem_in, sum_lo[bsel]};
      q_bit   = (trial >= {1'b0, count_q});
      rem_nx  = q_bit ? CNT_WIDTH'(trial - {1'b0, count_q}) : trial[CNT_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ACCUM;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = ACCUM;
      end else begin
         case (state_q)
            ACCUM:   if (start) state_d = now_empty ? DONE : DIVIDE;
            DIVIDE:  if (last_step && (idx_q == LAST_IDX)) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = ACCUM;
         endcase
      end
   end

   // Status flags are registered, so they trail the state by one cycle.
   always_comb begin
      busy_d  = !clear && (state_q == DIVIDE);
      valid_d = !clear && (state_q == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < COORD_NUM; i++) begin
            sum_q[i]  <= '0;
            cent_q[i] <= '0;
         end
         count_q <= '0;
         rem_q   <= '0;
         idx_q   <= '0;
         bit_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         empty_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         busy_q  <= busy_d;
         valid_q <= valid_d;
         if (clear) begin
            for (int i = 0; i < COORD_NUM; i++) sum_q[i] <= '0;
            count_q <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            bit_q   <= '0;
            empty_q <= 1'b0;
            ovf_q   <= 1'b0;
         end else begin
            if (add_pt) begin
               for (int i = 0; i < COORD_NUM; i++)
                  sum_q[i] <= sum_q[i] + SUM_W'(point_in[i*COORD_WIDTH +: COORD_WIDTH]);
               count_q <= count_q + CNT_WIDTH'(1);
            end
            if (take_pt && (&count_q)) ovf_q <= 1'b1;
            if (start) begin
               idx_q   <= '0;
               bit_q   <= '0;
               empty_q <= now_empty;
               if (now_empty)
                  for (int i = 0; i < COORD_NUM; i++)
                     cent_q[i] <= old_centroid_in[i*COORD_WIDTH +: COORD_WIDTH];
            end
            if (state_q == DIVIDE) begin
               cent_q[idx_q] <= {cent_q[idx_q][COORD_WIDTH-2:0], q_bit};
               rem_q         <= rem_nx;
               if (last_step) begin
                  bit_q <= '0;
                  idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
               end else begin
                  bit_q <= bit_q + BIT_W'(1);
               end
            end
         end
      end
   end

   for (genvar g = 0; g < COORD_NUM; g++) begin : g_out
      assign centroid_out[g*COORD_WIDTH +: COORD_WIDTH] = cent_q[g];
   end

   assign busy           = busy_q;
   assign centroid_valid = valid_q;
   assign count_out      = count_q;
   assign empty_cluster  = empty_q;
   assign overflow       = ovf_q;
endmodule

// File: tb/tb_cluster_accumulator.sv
// Directed bench for cluster_accumulator: means, floor rounding, empty cluster,
// simultaneous events, mid-division reset and counter saturation on a narrow instance.
module tb_cluster_accumulator;
   localparam int CN = 7;
   localparam int CW = 13;
   localparam int PW = CN * CW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear = 1'b0, point_valid = 1'b0, compute_start = 1'b0;
   logic [PW-1:0] point_in = '0, old_centroid_in = '0;
   logic          busy, centroid_valid, empty_cluster, overflow;
   logic [PW-1:0] centroid_out;
   logic [15:0]   count_out;

   logic          s_clear = 1'b0, s_pv = 1'b0, s_start = 1'b0;
   logic [PW-1:0] s_point = '0;
   logic          s_busy, s_valid, s_empty, s_ovf;
   logic [PW-1:0] s_cent;
   logic [3:0]    s_count;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cluster_accumulator #(.COORD_NUM(CN), .COORD_WIDTH(CW), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .point_valid(point_valid),
      .point_in(point_in), .old_centroid_in(old_centroid_in), .compute_start(compute_start),
      .busy(busy), .centroid_valid(centroid_valid), .centroid_out(centroid_out),
      .count_out(count_out), .empty_cluster(empty_cluster), .overflow(overflow));

   cluster_accumulator #(.COORD_NUM(CN), .COORD_WIDTH(CW), .CNT_WIDTH(4)) dut_small (
      .clk(clk), .rst_n(rst_n), .clear(s_clear), .point_valid(s_pv),
      .point_in(s_point), .old_centroid_in('0), .compute_start(s_start),
      .busy(s_busy), .centroid_valid(s_valid), .centroid_out(s_cent),
      .count_out(s_count), .empty_cluster(s_empty), .overflow(s_ovf));

   function automatic logic [PW-1:0] pack_all(input logic [CW-1:0] v);
      logic [PW-1:0] r;
      for (int i = 0; i < CN; i++) r[i*CW +: CW] = v;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic send_point(input logic [PW-1:0] p);
      point_valid = 1'b1;
      point_in    = p;
      tick();
      point_valid = 1'b0;
      point_in    = '0;
   endtask

   // lat counts clock edges from the compute_start sampling edge to centroid_valid.
   task automatic run_compute(input logic pv, input logic [PW-1:0] p, input logic noise,
                              output int lat, output int busy_cyc);
      compute_start = 1'b1;
      point_valid   = pv;
      point_in      = p;
      tick();
      compute_start = 1'b0;
      point_valid   = 1'b0;
      lat      = 0;
      busy_cyc = 0;
      while (!centroid_valid && lat < 200) begin
         if (busy) busy_cyc++;
         if (noise) begin
            point_valid = 1'b1;
            point_in    = pack_all(13'h1FFF);
         end
         tick();
         lat++;
      end
      point_valid = 1'b0;
      point_in    = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #13;
      checks++;
      if ({busy, centroid_valid, empty_cluster, overflow} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags got=%b want=0000", {busy, centroid_valid, empty_cluster, overflow});
      end
      checks++;
      if (count_out !== 16'd0 || centroid_out !== '0) begin
         failures++;
         $display("FAIL reset_data count=%0d centroid=%h want 0/0", count_out, centroid_out);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_mean();
      int lat, bc;
      send_point(pack_all(13'd10));
      send_point(pack_all(13'd20));
      send_point(pack_all(13'd30));
      send_point(pack_all(13'd40));
      checks++;
      if (count_out !== 16'd4) begin
         failures++;
         $display("FAIL mean_count got=%0d want=4", count_out);
      end
      run_compute(1'b0, '0, 1'b0, lat, bc);
      checks++;
      if (lat !== 92) begin
         failures++;
         $display("FAIL mean_latency got=%0d want=92", lat);
      end
      checks++;
      if (bc !== 91) begin
         failures++;
         $display("FAIL mean_busy_cycles got=%0d want=91", bc);
      end
      checks++;
      if (centroid_out !== pack_all(13'd25) || busy !== 1'b0 || empty_cluster !== 1'b0) begin
         failures++;
         $display("FAIL mean_result got=%h busy=%b empty=%b want=%h", centroid_out, busy,
                  empty_cluster, pack_all(13'd25));
      end
      tick();
      tick();
      checks++;
      if (centroid_valid !== 1'b1 || count_out !== 16'd4) begin
         failures++;
         $display("FAIL mean_done_hold valid=%b count=%0d want 1/4", centroid_valid, count_out);
      end
   endtask

   task automatic test_floor();
      int lat, bc;
      logic [PW-1:0] want;
      pulse_clear();
      checks++;
      if (centroid_out !== pack_all(13'd25) || centroid_valid !== 1'b0 || count_out !== 16'd0) begin
         failures++;
         $display("FAIL clear_retain centroid=%h valid=%b count=%0d", centroid_out, centroid_valid,
                  count_out);
      end
      send_point(PW'(1));
      send_point(PW'(2));
      run_compute(1'b0, '0, 1'b0, lat, bc);
      want = PW'(1);
      checks++;
      if (centroid_out !== want || lat !== 92) begin
         failures++;
         $display("FAIL floor_mean got=%h lat=%0d want=%h lat=92", centroid_out, lat, want);
      end
      pulse_clear();
      send_point(pack_all(13'h1FFF));
      send_point(pack_all(13'h1FFF));
      send_point(pack_all(13'h1FFF));
      run_compute(1'b0, '0, 1'b0, lat, bc);
      checks++;
      if (centroid_out !== pack_all(13'h1FFF)) begin
         failures++;
         $display("FAIL max_mean got=%h want=%h", centroid_out, pack_all(13'h1FFF));
      end
   endtask

   task automatic test_empty();
      int lat, bc;
      pulse_clear();
      old_centroid_in = pack_all(13'h155);
      run_compute(1'b0, '0, 1'b0, lat, bc);
      checks++;
      if (lat !== 1 || bc !== 0) begin
         failures++;
         $display("FAIL empty_timing lat=%0d busy_cycles=%0d want 1/0", lat, bc);
      end
      checks++;
      if (empty_cluster !== 1'b1 || centroid_out !== pack_all(13'h155) || count_out !== 16'd0) begin
         failures++;
         $display("FAIL empty_result empty=%b centroid=%h count=%0d want 1/%h/0", empty_cluster,
                  centroid_out, count_out, pack_all(13'h155));
      end
      old_centroid_in = '0;
   endtask

   task automatic test_simultaneous();
      int lat, bc;
      pulse_clear();
      send_point(pack_all(13'd2));
      run_compute(1'b1, pack_all(13'd6), 1'b1, lat, bc);
      checks++;
      if (count_out !== 16'd2 || centroid_out !== pack_all(13'd4) || lat !== 92) begin
         failures++;
         $display("FAIL start_with_point count=%0d centroid=%h lat=%0d want 2/%h/92", count_out,
                  centroid_out, lat, pack_all(13'd4));
      end
      pulse_clear();
      send_point(pack_all(13'd50));
      clear       = 1'b1;
      point_valid = 1'b1;
      point_in    = pack_all(13'd50);
      tick();
      clear       = 1'b0;
      point_valid = 1'b0;
      checks++;
      if (count_out !== 16'd0 || empty_cluster !== 1'b0) begin
         failures++;
         $display("FAIL clear_vs_point count=%0d empty=%b want 0/0", count_out, empty_cluster);
      end
      send_point(pack_all(13'd5));
      run_compute(1'b0, '0, 1'b0, lat, bc);
      checks++;
      if (centroid_out !== pack_all(13'd5)) begin
         failures++;
         $display("FAIL clear_sums got=%h want=%h", centroid_out, pack_all(13'd5));
      end
   endtask

   task automatic test_reset_mid_divide();
      int lat, bc;
      pulse_clear();
      send_point(pack_all(13'd300));
      send_point(pack_all(13'd301));
      compute_start = 1'b1;
      tick();
      compute_start = 1'b0;
      for (int i = 0; i < 40; i++) tick();
      rst_n = 1'b0;
      #2;
      checks++;
      if ({busy, centroid_valid, empty_cluster, overflow} !== 4'b0000 || count_out !== 16'd0
          || centroid_out !== '0) begin
         failures++;
         $display("FAIL mid_divide_reset flags=%b count=%0d centroid=%h want all 0",
                  {busy, centroid_valid, empty_cluster, overflow}, count_out, centroid_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      send_point(pack_all(13'd7));
      run_compute(1'b0, '0, 1'b0, lat, bc);
      checks++;
      if (centroid_out !== pack_all(13'd7) || lat !== 92) begin
         failures++;
         $display("FAIL after_reset_mean got=%h lat=%0d want=%h lat=92", centroid_out, lat,
                  pack_all(13'd7));
      end
   endtask

   task automatic test_overflow();
      int lat;
      s_clear = 1'b1;
      tick();
      s_clear = 1'b0;
      s_pv    = 1'b1;
      s_point = pack_all(13'd1);
      for (int i = 0; i < 17; i++) tick();
      s_pv    = 1'b0;
      s_point = '0;
      checks++;
      if (s_count !== 4'd15 || s_ovf !== 1'b1) begin
         failures++;
         $display("FAIL saturate count=%0d ovf=%b want 15/1", s_count, s_ovf);
      end
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      lat = 0;
      while (!s_valid && lat < 200) begin
         tick();
         lat++;
      end
      checks++;
      if (s_cent !== pack_all(13'd1) || lat !== 92) begin
         failures++;
         $display("FAIL saturate_mean got=%h lat=%0d want=%h lat=92", s_cent, lat, pack_all(13'd1));
      end
      s_clear = 1'b1;
      tick();
      s_clear = 1'b0;
      checks++;
      if (s_ovf !== 1'b0 || s_count !== 4'd0 || s_valid !== 1'b0) begin
         failures++;
         $display("FAIL saturate_clear ovf=%b count=%0d valid=%b want 0/0/0", s_ovf, s_count, s_valid);
      end
   endtask

   initial begin
      test_reset();
      test_mean();
      test_floor();
      test_empty();
      test_simultaneous();
      test_reset_mid_divide();
      test_overflow();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
